// File: rtl/cv32e40p_wfi_ctrl_if.sv
// Bundle of WFI sequencing signals between the core controller and the WFI block.
// The slave modport is the WFI controller; the master modport is its environment.
interface cv32e40p_wfi_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 wfi_valid_i;
    logic                 wfi_no_sleep_i;
    logic                 irq_pending_i;
    logic                 debug_req_i;
    logic                 if_busy_i;
    logic                 lsu_busy_i;
    logic                 apu_busy_i;
    logic                 cnt_clear_i;
    logic                 ctrl_busy_o;
    logic                 wake_from_sleep_o;
    logic                 wfi_stall_o;
    logic                 sleeping_o;
    logic                 wfi_done_o;
    logic [CNT_WIDTH-1:0] sleep_cnt_o;

    modport master (
        output wfi_valid_i, wfi_no_sleep_i, irq_pending_i, debug_req_i,
        output if_busy_i, lsu_busy_i, apu_busy_i, cnt_clear_i,
        input  ctrl_busy_o, wake_from_sleep_o, wfi_stall_o, sleeping_o,
        input  wfi_done_o, sleep_cnt_o
    );

    modport slave (
        input  wfi_valid_i, wfi_no_sleep_i, irq_pending_i, debug_req_i,
        input  if_busy_i, lsu_busy_i, apu_busy_i, cnt_clear_i,
        output ctrl_busy_o, wake_from_sleep_o, wfi_stall_o, sleeping_o,
        output wfi_done_o, sleep_cnt_o
    );
endinterface

// File: rtl/cv32e40p_wfi_ctrl.sv
// WFI sequencing ahead of the core sleep unit: drains outstanding activity after a
// retiring WFI, drops ctrl_busy so the clock can be gated, and on wake holds ID
// stalled for a fixed restart window before resuming.
module cv32e40p_wfi_ctrl #(
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input logic               clk_ungated_i,
    input logic               rst_i,
    cv32e40p_wfi_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StRun, StDrain, StSleep, StWake} state_e;

    localparam logic [3:0]           WakeLoad = 4'(WAKE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntMax   = {CNT_WIDTH{1'b1}};

    state_e               state_q;
    logic [3:0]           wake_cnt_q;
    logic [CNT_WIDTH-1:0] sleep_cnt_q;
    logic                 ctrl_busy_q;
    logic                 wfi_stall_q;
    logic                 sleeping_q;
    logic                 wfi_done_q;

    logic wake_cond;
    logic any_busy;
    logic sleep_hold;

    assign wake_cond  = bus.irq_pending_i | bus.debug_req_i;
    assign any_busy   = bus.if_busy_i | bus.lsu_busy_i | bus.apu_busy_i;
    // While asleep without a wake the clock may be gated, so nothing may change.
    assign sleep_hold = (state_q == StSleep) && !wake_cond;

    // Single FSM register block; all outputs except the wake request are registered.
    always_ff @(posedge clk_ungated_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StRun;
            wake_cnt_q  <= '0;
            sleep_cnt_q <= '0;
            ctrl_busy_q <= 1'b1;
            wfi_stall_q <= 1'b0;
            sleeping_q  <= 1'b0;
            wfi_done_q  <= 1'b0;
        end else begin
            wfi_done_q <= 1'b0;
            if (bus.cnt_clear_i && !sleep_hold) begin
                sleep_cnt_q <= '0;
            end
            case (state_q)
                StRun: begin
                    if (bus.wfi_valid_i) begin
                        if (bus.wfi_no_sleep_i || wake_cond) begin
                            // Executed as a NOP: complete without leaving RUN.
                            wfi_done_q <= 1'b1;
                        end else begin
                            state_q     <= StDrain;
                            wfi_stall_q <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    // A wake aborts the WFI even if the drain finishes this cycle.
                    if (wake_cond) begin
                        state_q     <= StRun;
                        wfi_stall_q <= 1'b0;
                        wfi_done_q  <= 1'b1;
                    end else if (!any_busy) begin
                        state_q     <= StSleep;
                        ctrl_busy_q <= 1'b0;
                        sleeping_q  <= 1'b1;
                        if (!bus.cnt_clear_i && (sleep_cnt_q != CntMax)) begin
                            sleep_cnt_q <= sleep_cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                StSleep: begin
                    if (wake_cond) begin
                        state_q     <= StWake;
                        wake_cnt_q  <= WakeLoad;
                        ctrl_busy_q <= 1'b1;
                        sleeping_q  <= 1'b0;
                    end
                end
                StWake: begin
                    if (wake_cnt_q == 4'd0) begin
                        state_q     <= StRun;
                        wfi_stall_q <= 1'b0;
                        wfi_done_q  <= 1'b1;
                    end else begin
                        wake_cnt_q <= wake_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    assign bus.ctrl_busy_o       = ctrl_busy_q;
    assign bus.wfi_stall_o       = wfi_stall_q;
    assign bus.sleeping_o        = sleeping_q;
    assign bus.wfi_done_o        = wfi_done_q;
    assign bus.sleep_cnt_o       = sleep_cnt_q;
    // Combinational so the sleep unit can ungate the clock in the same cycle.
    assign bus.wake_from_sleep_o = sleeping_q & wake_cond;

`ifndef SYNTHESIS
    a_sleep_idle : assert property (@(posedge clk_ungated_i) disable iff (rst_i)
        sleeping_q |-> !any_busy);
    a_busy_vs_sleep : assert property (@(posedge clk_ungated_i) disable iff (rst_i)
        ctrl_busy_q == !sleeping_q);
    a_sleep_stable : assert property (@(posedge clk_ungated_i) disable iff (rst_i)
        sleep_hold |=> $stable({state_q, wake_cnt_q, sleep_cnt_q, ctrl_busy_q,
                                wfi_stall_q, sleeping_q, wfi_done_q}));
    a_wfi_in_run : assert property (@(posedge clk_ungated_i) disable iff (rst_i)
        bus.wfi_valid_i |-> (state_q == StRun));
`endif

endmodule

// File: tb/tb_cv32e40p_wfi_ctrl.sv
// Directed bench for cv32e40p_wfi_ctrl. Two instances share stimulus: one with the
// default 16-bit sleep counter and one with a 2-bit counter for saturation.
module tb_cv32e40p_wfi_ctrl;

    localparam int unsigned WakeCycles = 2;
    localparam int MRun = 0, MDrain = 1, MSleep = 2, MWake = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic wfi_valid = 1'b0, wfi_no_sleep = 1'b0, irq_pending = 1'b0, debug_req = 1'b0;
    logic if_busy = 1'b0, lsu_busy = 1'b0, apu_busy = 1'b0, cnt_clear = 1'b0;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode, absolute edge of wake release, total sleep entries.
    int   m_mode    = MRun;
    int   m_sleeps  = 0;
    int   m_release = 0;
    int   edge_n    = 0;
    logic m_done    = 1'b0;
    logic wk;

    cv32e40p_wfi_ctrl_if #(.CNT_WIDTH(16)) bus_a ();
    cv32e40p_wfi_ctrl_if #(.CNT_WIDTH(2))  bus_b ();

    assign bus_a.wfi_valid_i = wfi_valid;    assign bus_b.wfi_valid_i = wfi_valid;
    assign bus_a.wfi_no_sleep_i = wfi_no_sleep; assign bus_b.wfi_no_sleep_i = wfi_no_sleep;
    assign bus_a.irq_pending_i = irq_pending; assign bus_b.irq_pending_i = irq_pending;
    assign bus_a.debug_req_i = debug_req;    assign bus_b.debug_req_i = debug_req;
    assign bus_a.if_busy_i = if_busy;        assign bus_b.if_busy_i = if_busy;
    assign bus_a.lsu_busy_i = lsu_busy;      assign bus_b.lsu_busy_i = lsu_busy;
    assign bus_a.apu_busy_i = apu_busy;      assign bus_b.apu_busy_i = apu_busy;
    assign bus_a.cnt_clear_i = cnt_clear;    assign bus_b.cnt_clear_i = cnt_clear;

    cv32e40p_wfi_ctrl #(.WAKE_CYCLES(WakeCycles), .CNT_WIDTH(16)) u_dut_a (
        .clk_ungated_i (clk),
        .rst_i         (rst),
        .bus           (bus_a)
    );

    cv32e40p_wfi_ctrl #(.WAKE_CYCLES(WakeCycles), .CNT_WIDTH(2)) u_dut_b (
        .clk_ungated_i (clk),
        .rst_i         (rst),
        .bus           (bus_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model update on every active edge (or asynchronous reset).
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_mode   = MRun;
                m_sleeps = 0;
                m_done   = 1'b0;
            end else begin
                edge_n++;
                wk     = irq_pending | debug_req;
                m_done = 1'b0;
                if (cnt_clear && !(m_mode == MSleep && !wk)) m_sleeps = 0;
                case (m_mode)
                    MRun: if (wfi_valid) begin
                        if (wfi_no_sleep || wk) m_done = 1'b1;
                        else m_mode = MDrain;
                    end
                    MDrain: if (wk) begin
                        m_mode = MRun;
                        m_done = 1'b1;
                    end else if (!(if_busy | lsu_busy | apu_busy)) begin
                        m_mode = MSleep;
                        if (!cnt_clear) m_sleeps++;
                    end
                    MSleep: if (wk) begin
                        m_mode    = MWake;
                        m_release = edge_n + WakeCycles;
                    end
                    default: if (edge_n == m_release) begin
                        m_mode = MRun;
                        m_done = 1'b1;
                    end
                endcase
            end
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        chk("a.ctrl_busy", int'(bus_a.ctrl_busy_o), int'(m_mode != MSleep));
        chk("a.wfi_stall", int'(bus_a.wfi_stall_o), int'(m_mode != MRun));
        chk("a.sleeping", int'(bus_a.sleeping_o), int'(m_mode == MSleep));
        chk("a.wake", int'(bus_a.wake_from_sleep_o),
            int'(m_mode == MSleep && (irq_pending || debug_req)));
        chk("a.done", int'(bus_a.wfi_done_o), int'(m_done));
        chk("a.cnt", int'(bus_a.sleep_cnt_o), (m_sleeps > 65535) ? 65535 : m_sleeps);
        chk("b.ctrl_busy", int'(bus_b.ctrl_busy_o), int'(m_mode != MSleep));
        chk("b.wfi_stall", int'(bus_b.wfi_stall_o), int'(m_mode != MRun));
        chk("b.done", int'(bus_b.wfi_done_o), int'(m_done));
        chk("b.cnt", int'(bus_b.sleep_cnt_o), (m_sleeps > 3) ? 3 : m_sleeps);
    end

    initial begin
        #1 rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("rst.busy", int'(bus_a.ctrl_busy_o), 1);
        chk("rst.stall", int'(bus_a.wfi_stall_o), 0);
        chk("rst.done", int'(bus_a.wfi_done_o), 0);
        chk("rst.cnt", int'(bus_a.sleep_cnt_o), 0);

        // WFI with IF busy: three DRAIN cycles, then SLEEP.
        if_busy = 1'b1; wfi_valid = 1'b1;
        tick(1);
        wfi_valid = 1'b0;
        chk("drain.stall", int'(bus_a.wfi_stall_o), 1);
        tick(2);
        chk("drain.busy", int'(bus_a.ctrl_busy_o), 1);
        if_busy = 1'b0;
        tick(1);
        chk("sleep.busy", int'(bus_a.ctrl_busy_o), 0);
        chk("sleep.cnt", int'(bus_a.sleep_cnt_o), 1);

        // Sleep 10 cycles, then a one-cycle interrupt.
        tick(10);
        chk("sleep.hold", int'(bus_a.sleeping_o), 1);
        irq_pending = 1'b1;
        #1;
        chk("wake.comb", int'(bus_a.wake_from_sleep_o), 1);
        tick(1);
        irq_pending = 1'b0;
        chk("wake.stall1", int'(bus_a.wfi_stall_o), 1);
        chk("wake.req_low", int'(bus_a.wake_from_sleep_o), 0);
        tick(1);
        chk("wake.stall2", int'(bus_a.wfi_stall_o), 1);
        tick(1);
        chk("wake.release", int'(bus_a.wfi_stall_o), 0);
        chk("wake.done", int'(bus_a.wfi_done_o), 1);
        tick(1);
        chk("wake.done_once", int'(bus_a.wfi_done_o), 0);

        // WFI as a NOP.
        wfi_no_sleep = 1'b1; wfi_valid = 1'b1;
        tick(1);
        wfi_valid = 1'b0; wfi_no_sleep = 1'b0;
        chk("nop.busy", int'(bus_a.ctrl_busy_o), 1);
        chk("nop.done", int'(bus_a.wfi_done_o), 1);
        chk("nop.cnt", int'(bus_a.sleep_cnt_o), 1);
        tick(1);

        // WFI with an interrupt already pending never sleeps.
        irq_pending = 1'b1; wfi_valid = 1'b1;
        tick(1);
        wfi_valid = 1'b0; irq_pending = 1'b0;
        chk("pend.done", int'(bus_a.wfi_done_o), 1);
        chk("pend.stall", int'(bus_a.wfi_stall_o), 0);
        tick(1);

        // WFI with LSU busy, aborted by a debug request in DRAIN.
        lsu_busy = 1'b1; wfi_valid = 1'b1;
        tick(1);
        wfi_valid = 1'b0;
        tick(2);
        debug_req = 1'b1;
        tick(1);
        debug_req = 1'b0; lsu_busy = 1'b0;
        chk("abort.stall", int'(bus_a.wfi_stall_o), 0);
        chk("abort.done", int'(bus_a.wfi_done_o), 1);
        chk("abort.cnt", int'(bus_a.sleep_cnt_o), 1);
        tick(1);

        // Five sleep/wake rounds: narrow counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            wfi_valid = 1'b1;
            tick(1);
            wfi_valid = 1'b0;
            tick(3);
            irq_pending = 1'b1;
            tick(1);
            irq_pending = 1'b0;
            tick(3);
        end
        chk("sat.wide", int'(bus_a.sleep_cnt_o), 6);
        chk("sat.narrow", int'(bus_b.sleep_cnt_o), 3);

        // Clear coincident with a SLEEP entry wins.
        wfi_valid = 1'b1;
        tick(1);
        wfi_valid = 1'b0;
        cnt_clear = 1'b1;
        tick(1);
        cnt_clear = 1'b0;
        chk("clr.sleep", int'(bus_a.sleeping_o), 1);
        chk("clr.wide", int'(bus_a.sleep_cnt_o), 0);
        chk("clr.narrow", int'(bus_b.sleep_cnt_o), 0);
        tick(2);

        // Asynchronous reset while in SLEEP.
        #2 rst = 1'b1;
        #1;
        chk("arst_sleep.busy", int'(bus_a.ctrl_busy_o), 1);
        chk("arst_sleep.stall", int'(bus_a.wfi_stall_o), 0);
        chk("arst_sleep.sleeping", int'(bus_a.sleeping_o), 0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // Asynchronous reset while in WAKE.
        wfi_valid = 1'b1;
        tick(1);
        wfi_valid = 1'b0;
        tick(2);
        chk("pre_wake.cnt", int'(bus_a.sleep_cnt_o), 1);
        irq_pending = 1'b1;
        tick(1);
        irq_pending = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_wake.busy", int'(bus_a.ctrl_busy_o), 1);
        chk("arst_wake.stall", int'(bus_a.wfi_stall_o), 0);
        chk("arst_wake.cnt", int'(bus_a.sleep_cnt_o), 0);
        tick(1);
        rst = 1'b0;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cv32e40p_wfi_ctrl.md
Name: cv32e40p_wfi_ctrl

Overview:
- WFI sequencing block directly upstream of the core sleep unit.
- Produces the ctrl_busy and wake_from_sleep signals that the sleep unit uses to gate and ungate the core clock.
- Accepts a retiring WFI from the ID stage, drains the outstanding IF/LSU/APU activity, then drops busy so the core clock can be gated.
- Raises wake on a pending interrupt or debug request, then holds ID stalled for a programmable restart window before resuming.
- Clocked by the ungated clock; holds all state constant while sleeping, so the environment may also gate clk_ungated_i.

Parameters:
- WAKE_CYCLES, 2: number of cycles ID is held stalled after wake. Legal range 1..15.
- CNT_WIDTH, 16: width of the saturating sleep-entry counter.

Ports:
- clk_ungated_i  input  1  free-running core clock
- rst_i  input  1  reset, asynchronous, active-high
- wfi_valid_i  input  1  WFI instruction retiring in ID this cycle (single-cycle pulse)
- wfi_no_sleep_i  input  1  debug mode, single step or trigger match; WFI is executed as a NOP
- irq_pending_i  input  1  any enabled interrupt pending, independent of mstatus.MIE
- debug_req_i  input  1  pending debug request
- if_busy_i  input  1  prefetcher has outstanding transactions
- lsu_busy_i  input  1  LSU has outstanding transactions
- apu_busy_i  input  1  APU operation in flight
- cnt_clear_i  input  1  synchronous clear of sleep_cnt_o
- ctrl_busy_o  output  1  to sleep unit; 0 only in SLEEP
- wake_from_sleep_o  output  1  to sleep unit; wake request
- wfi_stall_o  output  1  stall ID/controller
- sleeping_o  output  1  state == SLEEP
- wfi_done_o  output  1  one-cycle pulse when a WFI completes
- sleep_cnt_o  output  CNT_WIDTH  number of SLEEP entries, saturating

Behaviour:
- Reset (rst_i high, asynchronous) drives:
  - state = RUN, wake counter = 0, sleep_cnt_o = 0
  - ctrl_busy_o = 1, wfi_stall_o = 0, wfi_done_o = 0
- Reset asserted mid-operation from any state returns to RUN immediately.
- Define wake_cond = irq_pending_i | debug_req_i.
- State machine: RUN, DRAIN, SLEEP, WAKE.
- RUN:
  - ctrl_busy_o = 1, wfi_stall_o = 0.
  - wfi_valid_i & wfi_no_sleep_i: stay in RUN; wfi_done_o pulses the next cycle (registered).
  - wfi_valid_i & !wfi_no_sleep_i & wake_cond: stay in RUN; wfi_done_o pulses the next cycle. A WFI with a wake already present never sleeps.
  - wfi_valid_i & !wfi_no_sleep_i & !wake_cond: go to DRAIN.
- DRAIN:
  - ctrl_busy_o = 1, wfi_stall_o = 1.
  - If wake_cond: go to RUN and pulse wfi_done_o. This abort has priority over drain completion.
  - Else if !(if_busy_i | lsu_busy_i | apu_busy_i): go to SLEEP and increment sleep_cnt_o (saturating at all-ones).
- SLEEP:
  - ctrl_busy_o = 0, wfi_stall_o = 1, sleeping_o = 1.
  - wake_from_sleep_o = wake_cond, combinational, so the sleep unit can enable the clock in the same cycle.
  - On wake_cond: go to WAKE and load the counter with WAKE_CYCLES-1.
  - No register changes while !wake_cond.
- WAKE:
  - ctrl_busy_o = 1, wfi_stall_o = 1.
  - Counter decrements each cycle.
  - When the counter is 0: go to RUN and pulse wfi_done_o on that transition.
  - wake_cond deassertion during WAKE is ignored.
- wake_from_sleep_o is 0 in every state except SLEEP.
- Latency: drained WFI to ctrl_busy_o = 0 is 1 cycle after the drain condition. Wake to wfi_stall_o = 0 is WAKE_CYCLES+1 cycles.
- wfi_valid_i outside RUN is ignored. It is a protocol error, flagged by an assertion.
- cnt_clear_i has priority over the increment in the same cycle; the counter reads 0 next cycle.
- Assertions:
  - sleeping_o implies !if_busy_i & !lsu_busy_i & !apu_busy_i.
  - ctrl_busy_o == !sleeping_o.
  - All state is stable during SLEEP while !wake_cond.

Test Plan:
- WFI with IF busy for 3 cycles, no irq → DRAIN for 3 cycles, then SLEEP; ctrl_busy_o = 0; sleep_cnt_o = 1.
- SLEEP for 10 cycles, then irq_pending_i = 1 for 1 cycle (WAKE_CYCLES = 2) → wake_from_sleep_o = 1 in that cycle; wfi_stall_o falls 3 cycles later; wfi_done_o pulses once.
- WFI with wfi_no_sleep_i = 1 → stays in RUN; ctrl_busy_o stays 1; wfi_done_o pulses next cycle; sleep_cnt_o unchanged.
- WFI while lsu_busy_i = 1, then debug_req_i rises during DRAIN → returns to RUN without ever reaching SLEEP; sleep_cnt_o unchanged.
- CNT_WIDTH = 2 with 5 sleep/wake cycles → sleep_cnt_o saturates at 3; cnt_clear_i asserted simultaneously with a SLEEP entry → 0.
- rst_i asserted asynchronously in SLEEP and in WAKE → immediately state = RUN, ctrl_busy_o = 1, wfi_stall_o = 0, sleep_cnt_o = 0.
